// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared definitions for the instruction-RAM byte-stream
//                loader: FSM state encoding and frame word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Bytes per RAM word; words arrive big-endian (high byte first).
    localparam int WORD_BYTES = 2;

    // Loader FSM state encoding (explicit 3-bit width).
    typedef logic [2:0] state_t;

    localparam state_t LEN_HI  = 3'd0;  // waiting for word-count high byte
    localparam state_t LEN_LO  = 3'd1;  // waiting for word-count low byte
    localparam state_t DATA_HI = 3'd2;  // waiting for data word high byte
    localparam state_t DATA_LO = 3'd3;  // waiting for data word low byte
    localparam state_t WRITE   = 3'd4;  // one-cycle RAM write strobe
    localparam state_t CSUM    = 3'd5;  // waiting for checksum byte
    localparam state_t DONE    = 3'd6;  // image loaded, processor released
    localparam state_t ERR     = 3'd7;  // frame rejected

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_csum.sv
`default_nettype none
// ============================================================================
//  Module      : loader_csum
//  Description : 8-bit mod-256 running-sum accumulator over frame bytes.
//                o_is_zero reports whether the sum *including the byte
//                currently presented on i_byte* is zero, so the caller can
//                judge the checksum byte in the same cycle it is transferred.
//  Ports       : clk       - clock
//                rst       - synchronous active-high reset, clears the sum
//                i_add     - accumulate i_byte at this clock edge
//                i_byte    - byte being transferred
//                o_is_zero - (sum + i_byte) mod 256 == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic       o_is_zero
);

    logic [7:0] r_sum;
    logic [7:0] w_sum_next;

    assign w_sum_next = r_sum + i_byte;
    assign o_is_zero  = (w_sum_next == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else if (i_add) begin
            r_sum <= w_sum_next;
        end
    end

endmodule : loader_csum
`default_nettype wire

// File: rtl/ir_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ir_loader
//  Description : Byte-stream program loader. Parses a frame of
//                {LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, [CSUM]} and writes
//                the N big-endian 16-bit words into instruction RAM starting
//                at address 0. exec is raised only once a full frame has been
//                accepted; error is raised (sticky) when a frame is rejected.
//  Build option: LOADER_CHECKSUM_EN - adds a trailing checksum byte; the
//                mod-256 sum of all frame bytes must be zero.
//  Ports       : clock    - clock, all state changes on posedge
//                reset    - synchronous active-high reset
//                rx_data  - incoming byte
//                rx_valid - rx_data valid this cycle
//                rx_ready - loader accepts a byte this cycle
//                m_data   - RAM write data
//                m_addr   - RAM write address
//                m_wren   - RAM write enable, one-cycle pulse per word
//                busy     - frame in progress
//                exec     - processor run enable (DONE only)
//                error    - frame error (ERR only)
//  Revision    : 1.0 - initial release
// ============================================================================
module ir_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [8*WORD_BYTES-1:0] m_data,
    output logic [ADDR_W-1:0]       m_addr,
    output logic                    m_wren,
    output logic                    busy,
    output logic                    exec,
    output logic                    error
);

    // Length limit widened by one bit so MAX_WORDS up to 65536 compares cleanly.
    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    // State entered once the last word (or an empty length) has been handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t c_after_frame = CSUM;
`else
    localparam state_t c_after_frame = DONE;
`endif

    state_t      r_state;
    state_t      w_next_state;

    logic        w_xfer;
    logic [7:0]  r_len_hi;
    logic [7:0]  r_data_hi;
    logic [15:0] r_len;
    logic [15:0] r_written;
    logic [15:0] w_written_inc;
    logic [15:0] w_len_rx;
    logic        w_len_too_big;
    logic        w_csum_ok;

    logic        w_rx_ready_d;
    logic        w_wren_d;
    logic        w_busy_d;
    logic        w_exec_d;
    logic        w_error_d;

    // A byte moves only when both sides agree; rx_ready is registered, so
    // rx_valid is naturally ignored in WRITE/DONE/ERR.
    assign w_xfer        = rx_valid & rx_ready;
    assign w_len_rx      = {r_len_hi, rx_data};
    assign w_len_too_big = ({1'b0, w_len_rx} > c_max_words);
    assign w_written_inc = r_written + 16'd1;

`ifdef LOADER_CHECKSUM_EN
    loader_csum u_csum (
        .clk       (clock),
        .rst       (reset),
        .i_add     (w_xfer),
        .i_byte    (rx_data),
        .o_is_zero (w_csum_ok)
    );
`else
    // CSUM is unreachable without the checksum option.
    assign w_csum_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register (registered outputs follow the next state so that
    // every output is a flop and is valid for the whole state cycle).
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= LEN_HI;
            rx_ready <= 1'b0;
            m_wren   <= 1'b0;
            busy     <= 1'b0;
            exec     <= 1'b0;
            error    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            rx_ready <= w_rx_ready_d;
            m_wren   <= w_wren_d;
            busy     <= w_busy_d;
            exec     <= w_exec_d;
            error    <= w_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LEN_HI: begin
                if (w_xfer) w_next_state = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_rx == 16'd0) begin
                        w_next_state = c_after_frame;
                    end else if (w_len_too_big) begin
                        w_next_state = ERR;
                    end else begin
                        w_next_state = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (w_xfer) w_next_state = DATA_LO;
            end
            DATA_LO: begin
                if (w_xfer) w_next_state = WRITE;
            end
            WRITE: begin
                // r_written counts words completed before this one.
                if (w_written_inc == r_len) begin
                    w_next_state = c_after_frame;
                end else begin
                    w_next_state = DATA_HI;
                end
            end
            CSUM: begin
                if (w_xfer) w_next_state = w_csum_ok ? DONE : ERR;
            end
            DONE:    w_next_state = DONE;
            ERR:     w_next_state = ERR;
            default: w_next_state = ERR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode, evaluated on the next state and then registered.
    // ------------------------------------------------------------------
    always_comb begin
        w_rx_ready_d = 1'b0;
        w_wren_d     = 1'b0;
        w_busy_d     = 1'b0;
        w_exec_d     = 1'b0;
        w_error_d    = 1'b0;
        case (w_next_state)
            LEN_HI:  w_rx_ready_d = 1'b1;
            LEN_LO, DATA_HI, DATA_LO, CSUM: begin
                w_rx_ready_d = 1'b1;
                w_busy_d     = 1'b1;
            end
            WRITE: begin
                w_wren_d = 1'b1;
                w_busy_d = 1'b1;
            end
            DONE:    w_exec_d  = 1'b1;
            ERR:     w_error_d = 1'b1;
            default: w_error_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length capture, word assembly, address/word counters.
    // m_addr advances at the end of the WRITE cycle so it is stable while
    // m_wren is high; after the last word it equals N (mod 2**ADDR_W).
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len_hi  <= 8'h00;
            r_len     <= 16'd0;
            r_data_hi <= 8'h00;
            r_written <= 16'd0;
            m_data    <= '0;
            m_addr    <= '0;
        end else begin
            if (w_xfer && (r_state == LEN_HI)) begin
                r_len_hi <= rx_data;
            end
            if (w_xfer && (r_state == LEN_LO)) begin
                r_len <= w_len_rx;
            end
            if (w_xfer && (r_state == DATA_HI)) begin
                r_data_hi <= rx_data;
            end
            if (w_xfer && (r_state == DATA_LO)) begin
                m_data <= {r_data_hi, rx_data};
            end
            if (r_state == WRITE) begin
                m_addr    <= m_addr + ADDR_W'(1);
                r_written <= w_written_inc;
            end
        end
    end

endmodule : ir_loader
`default_nettype wire

// File: tb/tb_ir_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ir_loader
//  Description : Self-checking bench for ir_loader. A reference model turns a
//                list of words into the expected frame bytes and the expected
//                RAM write sequence (word i at address i); a negedge monitor
//                records every write and flags protocol violations.
//                Checksum scenarios are built when LOADER_CHECKSUM_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_loader;

    localparam int ADDR_W    = 12;
    localparam int MAX_WORDS = 4096;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [15:0]       m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wren;
    logic              busy;
    logic              exec;
    logic              error;

    always #5 clock = ~clock;

    ir_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .m_data   (m_data),
        .m_addr   (m_addr),
        .m_wren   (m_wren),
        .busy     (busy),
        .exec     (exec),
        .error    (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model inputs/outputs
    logic [15:0] exp_words[$];
    logic [7:0]  frame[$];

    // Monitor state (written only by the monitor)
    logic [ADDR_W-1:0] wa_q[$];
    logic [15:0]       wd_q[$];
    int   n_xfer = 0, cyc = 0, last_xfer_cyc = -10;
    int   bad_pulse = 0, bad_order = 0, bad_latency = 0;
    logic prev_wren = 1'b0, busy_seen = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            wa_q.delete(); wd_q.delete();
            n_xfer = 0; last_xfer_cyc = -10; prev_wren = 1'b0; busy_seen = 1'b0;
            bad_pulse = 0; bad_order = 0; bad_latency = 0;
        end else begin
            if (m_wren === 1'b1) begin
                if (prev_wren) bad_pulse++;
                // both length bytes plus both bytes of every word so far
                if (n_xfer < 2 + 2 * (wa_q.size() + 1)) bad_order++;
                if (last_xfer_cyc != cyc - 1) bad_latency++;
                wa_q.push_back(m_addr);
                wd_q.push_back(m_data);
            end
            prev_wren = (m_wren === 1'b1);
            if (busy === 1'b1) busy_seen = 1'b1;
            if (rx_valid && rx_ready === 1'b1) begin
                n_xfer++;
                last_xfer_cyc = cyc;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic build_frame(input int n);
        logic [15:0] nn;
        logic [7:0]  s;
        nn = 16'(n);
        frame.delete();
        frame.push_back(nn[15:8]);
        frame.push_back(nn[7:0]);
        foreach (exp_words[i]) begin
            frame.push_back(exp_words[i][15:8]);
            frame.push_back(exp_words[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        s = 8'h00;
        foreach (frame[i]) s = s + frame[i];
        frame.push_back(8'h00 - s);
`endif
    endtask

    // Offer one byte until accepted; returns at the negedge before the
    // transfer edge. gap_pct = chance per cycle of withholding rx_valid.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(posedge clock); #1;
            if (int'($urandom_range(99)) < gap_pct) begin
                rx_valid = 1'b0; rx_data = 8'($urandom);
            end else begin
                rx_valid = 1'b1; rx_data = b;
            end
            @(negedge clock);
            if (rx_valid && rx_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic end_stream();
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap_pct, output bit ok);
        ok = 1'b1;
        foreach (frame[i]) begin
            if (ok) send_byte(frame[i], gap_pct, ok);
        end
        end_stream();
    endtask

    task automatic wait_end(output bit timed_out);
        timed_out = 1'b1;
        for (int t = 0; t < 500 && timed_out; t++) begin
            @(negedge clock);
            if (exec === 1'b1 || error === 1'b1) timed_out = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if ({rx_ready, m_wren, busy, exec, error} !== 5'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 00000", {rx_ready, m_wren, busy, exec, error}); end
        n_checks++; if (m_addr !== '0) begin n_errors++; $display("FAIL reset_addr: got %0h want 0", m_addr); end
        n_checks++; if (m_data !== 16'h0) begin n_errors++; $display("FAIL reset_data: got %0h want 0", m_data); end
        @(posedge clock); #1 reset = 1'b0; rx_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        n_checks++; if (rx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after: got %b want 1", rx_ready); end
        n_checks++; if (busy !== 1'b0 || exec !== 1'b0) begin n_errors++; $display("FAIL reset_idle: got busy=%b exec=%b want 0 0", busy, exec); end
    endtask

    task automatic test_basic();
        bit ok, to;
        do_reset();
        exp_words = '{16'h1234, 16'hABCD};
        build_frame(2);
        run_frame(0, ok);
        wait_end(to);
        n_checks++; if (!ok || to) begin n_errors++; $display("FAIL basic_complete: got ok=%b timeout=%b want 1 0", ok, to); end
        n_checks++; if (wa_q.size() != 2) begin n_errors++; $display("FAIL basic_nwrites: got %0d want 2", wa_q.size()); end
        foreach (exp_words[i]) if (i < wa_q.size()) begin
            n_checks++; if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_words[i]) begin n_errors++; $display("FAIL basic_write[%0d]: got (%0h,%0h) want (%0h,%0h)", i, wa_q[i], wd_q[i], i, exp_words[i]); end
        end
        n_checks++; if (exec !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL basic_exec: got exec=%b error=%b want 1 0", exec, error); end
        n_checks++; if (m_addr !== ADDR_W'(2)) begin n_errors++; $display("FAIL basic_addr: got %0h want 2", m_addr); end
        n_checks++; if (busy_seen !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy: got seen=%b now=%b want 1 0", busy_seen, busy); end
        n_checks++; if (bad_pulse != 0 || bad_latency != 0 || bad_order != 0) begin n_errors++; $display("FAIL basic_protocol: got pulse=%0d lat=%0d order=%0d want 0 0 0", bad_pulse, bad_latency, bad_order); end
        // DONE must ignore further traffic
        repeat (10) begin @(posedge clock); #1 rx_valid = 1'b1; rx_data = 8'($urandom); end
        end_stream(); @(negedge clock);
        n_checks++; if (rx_ready !== 1'b0 || exec !== 1'b1 || wa_q.size() != 2) begin n_errors++; $display("FAIL basic_terminal: got ready=%b exec=%b writes=%0d want 0 1 2", rx_ready, exec, wa_q.size()); end
    endtask

    task automatic test_zero_len();
        bit ok, to;
        do_reset();
        exp_words.delete();
        build_frame(0);
        run_frame(0, ok);
`ifndef LOADER_CHECKSUM_EN
        @(negedge clock);
        n_checks++; if (exec !== 1'b1) begin n_errors++; $display("FAIL zero_exec_timing: got %b want 1", exec); end
`endif
        wait_end(to);
        n_checks++; if (!ok || to || exec !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL zero_done: got ok=%b to=%b exec=%b err=%b want 1 0 1 0", ok, to, exec, error); end
        n_checks++; if (wa_q.size() != 0 || m_addr !== '0) begin n_errors++; $display("FAIL zero_nowrite: got writes=%0d addr=%0h want 0 0", wa_q.size(), m_addr); end
    endtask

    task automatic test_too_long();
        bit ok;
        do_reset();
        frame = '{8'h10, 8'h01};
        run_frame(0, ok);
        @(negedge clock);
        n_checks++; if (error !== 1'b1 || exec !== 1'b0 || rx_ready !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL toolong_err: got err=%b exec=%b ready=%b busy=%b want 1 0 0 0", error, exec, rx_ready, busy); end
        repeat (5) @(negedge clock);
        n_checks++; if (wa_q.size() != 0 || error !== 1'b1) begin n_errors++; $display("FAIL toolong_sticky: got writes=%0d err=%b want 0 1", wa_q.size(), error); end
    endtask

    task automatic test_max_len();
        bit ok, to;
        int nbad;
        do_reset();
        exp_words.delete();
        for (int i = 0; i < MAX_WORDS; i++) exp_words.push_back(16'($urandom));
        build_frame(MAX_WORDS);
        run_frame(10, ok);
        wait_end(to);
        n_checks++; if (!ok || to || exec !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL max_done: got ok=%b to=%b exec=%b err=%b want 1 0 1 0", ok, to, exec, error); end
        n_checks++; if (m_addr !== '0) begin n_errors++; $display("FAIL max_addr_wrap: got %0h want 0", m_addr); end
        n_checks++; if (wa_q.size() != MAX_WORDS) begin n_errors++; $display("FAIL max_nwrites: got %0d want %0d", wa_q.size(), MAX_WORDS); end
        nbad = 0;
        foreach (exp_words[i]) if (i < wa_q.size() && (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_words[i])) nbad++;
        n_checks++; if (nbad != 0) begin n_errors++; $display("FAIL max_contents: got %0d bad words want 0", nbad); end
    endtask

    task automatic test_random_valid();
        bit ok, to;
        int n;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            exp_words.delete();
            if (it == 0) exp_words = '{16'h1234, 16'hABCD};
            else begin
                n = int'($urandom_range(24, 1));
                for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
            end
            build_frame(exp_words.size());
            run_frame(50, ok);
            wait_end(to);
            n_checks++; if (!ok || to || exec !== 1'b1) begin n_errors++; $display("FAIL rand%0d_done: got ok=%b to=%b exec=%b want 1 0 1", it, ok, to, exec); end
            n_checks++; if (wa_q.size() != exp_words.size() || m_addr !== ADDR_W'(exp_words.size())) begin n_errors++; $display("FAIL rand%0d_count: got writes=%0d addr=%0h want %0d", it, wa_q.size(), m_addr, exp_words.size()); end
            foreach (exp_words[i]) if (i < wa_q.size()) begin
                n_checks++; if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_words[i]) begin n_errors++; $display("FAIL rand%0d_write[%0d]: got (%0h,%0h) want (%0h,%0h)", it, i, wa_q[i], wd_q[i], i, exp_words[i]); end
            end
            n_checks++; if (bad_pulse != 0 || bad_latency != 0 || bad_order != 0) begin n_errors++; $display("FAIL rand%0d_protocol: got pulse=%0d lat=%0d order=%0d want 0 0 0", it, bad_pulse, bad_latency, bad_order); end
        end
    endtask

    task automatic test_midframe_reset();
        bit ok, to;
        logic [15:0] w0;
        do_reset();
        w0 = 16'($urandom);
        exp_words = '{w0, 16'($urandom), 16'($urandom)};
        build_frame(3);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (ok) send_byte(frame[i], 0, ok);
        end_stream();
        for (int t = 0; t < 20 && wa_q.size() == 0; t++) @(negedge clock);
        n_checks++; if (wa_q.size() != 1 || wd_q[0] !== w0 || wa_q[0] !== '0) begin n_errors++; $display("FAIL mid_first_word: got writes=%0d want 1 of (0,%0h)", wa_q.size(), w0); end
        do_reset();
        @(negedge clock);
        n_checks++; if (exec !== 1'b0 || m_addr !== '0 || busy !== 1'b0) begin n_errors++; $display("FAIL mid_after_reset: got exec=%b addr=%0h busy=%b want 0 0 0", exec, m_addr, busy); end
        exp_words = '{16'hBEEF};
        build_frame(1);
        run_frame(30, ok);
        wait_end(to);
        n_checks++; if (!ok || to || exec !== 1'b1) begin n_errors++; $display("FAIL mid_second_done: got ok=%b to=%b exec=%b want 1 0 1", ok, to, exec); end
        n_checks++; if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 16'hBEEF) begin n_errors++; $display("FAIL mid_second_write: got writes=%0d want 1 of (0,beef)", wa_q.size()); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok, to;
        do_reset();
        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
        run_frame(0, ok);
        wait_end(to);
        n_checks++; if (!ok || to || exec !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL csum_good: got ok=%b to=%b exec=%b err=%b want 1 0 1 0", ok, to, exec, error); end
        n_checks++; if (wa_q.size() != 1 || wd_q[0] !== 16'h1234) begin n_errors++; $display("FAIL csum_good_write: got writes=%0d want 1 of 1234", wa_q.size()); end
        do_reset();
        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hB8};
        run_frame(0, ok);
        wait_end(to);
        n_checks++; if (to || exec !== 1'b0 || error !== 1'b1) begin n_errors++; $display("FAIL csum_bad: got to=%b exec=%b err=%b want 0 0 1", to, exec, error); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_random_valid();
        test_midframe_reset();
        test_max_len();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ir_loader
`default_nettype wire
